// File: rtl/wr_ep_rx_sync_fsm_if.sv
// rtl/wr_ep_rx_sync_fsm_if.sv - decoded 8b/10b receive word bundle for the link-sync FSM
interface wr_ep_rx_sync_fsm_if #(
    parameter int BYTES = 2
);
    logic               rx_valid;
    logic [8*BYTES-1:0] rx_data;
    logic [BYTES-1:0]   rx_k;
    logic               rx_enc_err;

    modport master (output rx_valid, output rx_data, output rx_k, output rx_enc_err);
    modport slave  (input  rx_valid, input  rx_data, input  rx_k, input  rx_enc_err);
endinterface

// File: rtl/wr_ep_rx_sync_fsm.sv
// rtl/wr_ep_rx_sync_fsm.sv - comma acquisition, sync tracking and debounced link_up for the WR endpoint PCS
module wr_ep_rx_sync_fsm #(
    parameter int BYTES       = 2,
    parameter int ACQ_COMMAS  = 3,
    parameter int MAX_ERRS    = 4,
    parameter int GOOD_RUN    = 4,
    parameter int LINK_UP_DLY = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk_125m,
    input  logic                  rst_n,
    wr_ep_rx_sync_fsm_if.slave    rx,
    input  logic                  err_clr,
    output logic [1:0]            state,
    output logic                  sync_ok,
    output logic                  link_up,
    output logic                  comma_det,
    output logic [CNT_W-1:0]      err_total
);

    localparam int CC_W = $clog2(ACQ_COMMAS + 1);
    localparam int EL_W = $clog2(MAX_ERRS + 1);
    localparam int GC_W = $clog2(GOOD_RUN + 1);
    localparam int UC_W = $clog2(LINK_UP_DLY + 1);

    localparam logic [CC_W-1:0] ACQ_N  = CC_W'(ACQ_COMMAS);
    localparam logic [EL_W-1:0] MAX_N  = EL_W'(MAX_ERRS);
    localparam logic [GC_W-1:0] GOOD_N = GC_W'(GOOD_RUN);
    localparam logic [UC_W-1:0] UP_N   = UC_W'(LINK_UP_DLY);

    typedef enum logic [1:0] {
        ST_LOS  = 2'd0,
        ST_ACQ  = 2'd1,
        ST_SYNC = 2'd2
    } sync_state_e;

    sync_state_e       state_q, state_d;
    logic [CC_W-1:0]   comma_cnt_q, comma_cnt_d;
    logic [EL_W-1:0]   err_level_q, err_level_d;
    logic [GC_W-1:0]   good_cnt_q, good_cnt_d;
    logic [UC_W-1:0]   up_cnt_q, up_cnt_d;
    logic              sync_ok_q, sync_ok_d;
    logic              link_up_q, link_up_d;
    logic              comma_det_q, comma_det_d;
    logic [CNT_W-1:0]  err_total_q, err_total_d;

    logic misalign;
    logic top_comma;
    logic is_comma;
    logic is_bad;

    // A comma on any lane but the top one means the word boundary has slipped.
    always_comb begin
        misalign = 1'b0;
        for (int i = 0; i < BYTES - 1; i++) begin
            if (rx.rx_k[i] && (rx.rx_data[8*i +: 8] == 8'hBC)) begin
                misalign = 1'b1;
            end
        end
    end

    assign top_comma = rx.rx_k[BYTES-1] && (rx.rx_data[8*(BYTES-1) +: 8] == 8'hBC);
    assign is_comma  = rx.rx_valid && top_comma && !misalign && !rx.rx_enc_err;
    assign is_bad    = rx.rx_valid && (rx.rx_enc_err || misalign);

    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        err_level_d = err_level_q;
        good_cnt_d  = good_cnt_q;
        up_cnt_d    = up_cnt_q;
        comma_det_d = is_comma;
        err_total_d = err_total_q;

        if (rx.rx_valid) begin
            case (state_q)
                ST_LOS: begin
                    if (is_comma) begin
                        if (ACQ_COMMAS == 1) begin
                            state_d     = ST_SYNC;
                            comma_cnt_d = '0;
                            err_level_d = '0;
                            good_cnt_d  = '0;
                            up_cnt_d    = '0;
                        end else begin
                            state_d     = ST_ACQ;
                            comma_cnt_d = CC_W'(1);
                        end
                    end
                end
                ST_ACQ: begin
                    if (is_comma) begin
                        if (comma_cnt_q + CC_W'(1) == ACQ_N) begin
                            state_d     = ST_SYNC;
                            comma_cnt_d = '0;
                            err_level_d = '0;
                            good_cnt_d  = '0;
                            up_cnt_d    = '0;
                        end else begin
                            comma_cnt_d = comma_cnt_q + CC_W'(1);
                        end
                    end else if (is_bad) begin
                        state_d     = ST_LOS;
                        comma_cnt_d = '0;
                    end
                end
                ST_SYNC: begin
                    // Bad words still count toward the link_up debounce.
                    if (up_cnt_q != UP_N) begin
                        up_cnt_d = up_cnt_q + UC_W'(1);
                    end
                    if (is_bad) begin
                        good_cnt_d = '0;
                        if (err_level_q + EL_W'(1) == MAX_N) begin
                            state_d     = ST_LOS;
                            err_level_d = '0;
                            up_cnt_d    = '0;
                        end else begin
                            err_level_d = err_level_q + EL_W'(1);
                        end
                    end else if (err_level_q != '0) begin
                        if (good_cnt_q + GC_W'(1) == GOOD_N) begin
                            err_level_d = err_level_q - EL_W'(1);
                            good_cnt_d  = '0;
                        end else begin
                            good_cnt_d  = good_cnt_q + GC_W'(1);
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                default: begin
                    state_d     = ST_LOS;
                    comma_cnt_d = '0;
                end
            endcase
        end

        sync_ok_d = (state_d == ST_SYNC);
        link_up_d = (state_d == ST_SYNC) && (up_cnt_d == UP_N);

        // Clearing on a bad word still records that word.
        if (err_clr) begin
            err_total_d = is_bad ? CNT_W'(1) : '0;
        end else if (is_bad && !(&err_total_q)) begin
            err_total_d = err_total_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_125m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOS;
            comma_cnt_q <= '0;
            err_level_q <= '0;
            good_cnt_q  <= '0;
            up_cnt_q    <= '0;
            sync_ok_q   <= 1'b0;
            link_up_q   <= 1'b0;
            comma_det_q <= 1'b0;
            err_total_q <= '0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            err_level_q <= err_level_d;
            good_cnt_q  <= good_cnt_d;
            up_cnt_q    <= up_cnt_d;
            sync_ok_q   <= sync_ok_d;
            link_up_q   <= link_up_d;
            comma_det_q <= comma_det_d;
            err_total_q <= err_total_d;
        end
    end

    assign state     = state_q;
    assign sync_ok   = sync_ok_q;
    assign link_up   = link_up_q;
    assign comma_det = comma_det_q;
    assign err_total = err_total_q;

endmodule

// File: tb/tb_wr_ep_rx_sync_fsm.sv
// tb/tb_wr_ep_rx_sync_fsm.sv - directed-vector bench for wr_ep_rx_sync_fsm (2-lane/16-bit and 1-lane/4-bit builds)
module tb_wr_ep_rx_sync_fsm;

    logic clk_125m = 1'b0;
    logic rst_n;
    logic a_err_clr, b_err_clr;

    logic [1:0]  a_state, b_state;
    logic        a_sync_ok, a_link_up, a_comma_det;
    logic        b_sync_ok, b_link_up, b_comma_det;
    logic [15:0] a_err_total;
    logic [3:0]  b_err_total;

    int n_chk  = 0;
    int n_pass = 0;

    always #4 clk_125m = ~clk_125m;

    wr_ep_rx_sync_fsm_if #(.BYTES(2)) a_if ();
    wr_ep_rx_sync_fsm_if #(.BYTES(1)) b_if ();

    wr_ep_rx_sync_fsm #(.BYTES(2), .CNT_W(16)) dut_a (
        .clk_125m  (clk_125m),
        .rst_n     (rst_n),
        .rx        (a_if.slave),
        .err_clr   (a_err_clr),
        .state     (a_state),
        .sync_ok   (a_sync_ok),
        .link_up   (a_link_up),
        .comma_det (a_comma_det),
        .err_total (a_err_total)
    );

    wr_ep_rx_sync_fsm #(.BYTES(1), .CNT_W(4)) dut_b (
        .clk_125m  (clk_125m),
        .rst_n     (rst_n),
        .rx        (b_if.slave),
        .err_clr   (b_err_clr),
        .state     (b_state),
        .sync_ok   (b_sync_ok),
        .link_up   (b_link_up),
        .comma_det (b_comma_det),
        .err_total (b_err_total)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic drv_a(input logic v, input logic [15:0] d, input logic [1:0] k, input logic e);
        a_if.rx_valid   = v;
        a_if.rx_data    = d;
        a_if.rx_k       = k;
        a_if.rx_enc_err = e;
    endtask

    task automatic drv_b(input logic v, input logic [7:0] d, input logic k, input logic e);
        b_if.rx_valid   = v;
        b_if.rx_data    = d;
        b_if.rx_k       = k;
        b_if.rx_enc_err = e;
    endtask

    task automatic tick();
        @(posedge clk_125m);
        #1;
    endtask

    task automatic a_word(input logic v, input logic [15:0] d, input logic [1:0] k, input logic e);
        drv_a(v, d, k, e);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        a_err_clr = 1'b0;
        b_err_clr = 1'b0;
        drv_a(1'b0, 16'h0000, 2'b00, 1'b0);
        drv_b(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst_state", {30'd0, a_state}, 0);
        chk("rst_sync_ok", {31'd0, a_sync_ok}, 0);
        chk("rst_link_up", {31'd0, a_link_up}, 0);
        chk("rst_comma_det", {31'd0, a_comma_det}, 0);
        chk("rst_err_total", {16'd0, a_err_total}, 0);
        rst_n = 1'b1;
        tick();

        // acquisition: three aligned commas
        a_word(1'b1, 16'hBC50, 2'b10, 1'b0);
        chk("acq1_state", {30'd0, a_state}, 1);
        chk("acq1_comma", {31'd0, a_comma_det}, 1);
        a_word(1'b1, 16'hBC50, 2'b10, 1'b0);
        chk("acq2_state", {30'd0, a_state}, 1);
        chk("acq2_comma", {31'd0, a_comma_det}, 1);
        a_word(1'b1, 16'hBC50, 2'b10, 1'b0);
        chk("acq3_state", {30'd0, a_state}, 2);
        chk("acq3_sync_ok", {31'd0, a_sync_ok}, 1);
        chk("acq3_comma", {31'd0, a_comma_det}, 1);
        chk("acq3_link_up", {31'd0, a_link_up}, 0);

        // link_up debounce with invalid words interleaved
        for (int i = 0; i < 16; i++) begin
            a_word(1'b1, 16'h1234, 2'b00, 1'b0);
            chk($sformatf("dbn_valid_%0d", i), {31'd0, a_link_up}, (i == 15) ? 1 : 0);
            chk($sformatf("dbn_comma_%0d", i), {31'd0, a_comma_det}, 0);
            a_word(1'b0, 16'hBC50, 2'b10, 1'b1);
            chk($sformatf("dbn_idle_%0d", i), {31'd0, a_link_up}, (i == 15) ? 1 : 0);
        end
        chk("dbn_err_total", {16'd0, a_err_total}, 0);

        // four consecutive errors drop sync
        for (int i = 0; i < 3; i++) begin
            a_word(1'b1, 16'h0000, 2'b00, 1'b1);
            chk($sformatf("err_hold_state_%0d", i), {30'd0, a_state}, 2);
            chk($sformatf("err_hold_link_%0d", i), {31'd0, a_link_up}, 1);
        end
        a_word(1'b1, 16'h0000, 2'b00, 1'b1);
        chk("err4_state", {30'd0, a_state}, 0);
        chk("err4_sync_ok", {31'd0, a_sync_ok}, 0);
        chk("err4_link_up", {31'd0, a_link_up}, 0);
        chk("err4_err_total", {16'd0, a_err_total}, 4);

        // reacquire, then 3 err / 4 good / 1 err keeps sync at level 3
        for (int i = 0; i < 3; i++) a_word(1'b1, 16'hBC50, 2'b10, 1'b0);
        chk("reacq_state", {30'd0, a_state}, 2);
        for (int i = 0; i < 3; i++) a_word(1'b1, 16'h0000, 2'b00, 1'b1);
        for (int i = 0; i < 4; i++) a_word(1'b1, 16'h5555, 2'b00, 1'b0);
        chk("lvl_good_state", {30'd0, a_state}, 2);
        a_word(1'b1, 16'h0000, 2'b00, 1'b1);
        chk("lvl3_state", {30'd0, a_state}, 2);
        chk("lvl3_sync_ok", {31'd0, a_sync_ok}, 1);
        chk("lvl3_err_total", {16'd0, a_err_total}, 8);
        a_word(1'b1, 16'h0000, 2'b00, 1'b1);
        chk("lvl4_state", {30'd0, a_state}, 0);
        chk("lvl4_err_total", {16'd0, a_err_total}, 9);

        // misaligned comma in ACQ
        a_word(1'b1, 16'hBC50, 2'b10, 1'b0);
        a_word(1'b1, 16'hBC50, 2'b10, 1'b0);
        chk("mis_pre_state", {30'd0, a_state}, 1);
        a_word(1'b1, 16'h50BC, 2'b01, 1'b0);
        chk("mis_state", {30'd0, a_state}, 0);
        chk("mis_comma", {31'd0, a_comma_det}, 0);
        chk("mis_err_total", {16'd0, a_err_total}, 10);

        // err_clr alone, then together with a bad word
        a_err_clr = 1'b1;
        a_word(1'b0, 16'h0000, 2'b00, 1'b0);
        chk("clr_alone", {16'd0, a_err_total}, 0);
        a_word(1'b1, 16'h0000, 2'b00, 1'b1);
        chk("clr_with_bad", {16'd0, a_err_total}, 1);
        a_err_clr = 1'b0;
        a_word(1'b0, 16'h0000, 2'b00, 1'b0);

        // 4-bit counter saturation on the 1-lane build
        for (int i = 0; i < 20; i++) begin
            drv_b(1'b1, 8'h00, 1'b0, 1'b1);
            tick();
            if (i == 14) chk("sat_reach", {28'd0, b_err_total}, 15);
        end
        chk("sat_hold", {28'd0, b_err_total}, 15);
        b_err_clr = 1'b1;
        tick();
        chk("sat_clr_bad", {28'd0, b_err_total}, 1);
        b_err_clr = 1'b0;

        // 1-lane comma acquisition
        drv_b(1'b1, 8'hBC, 1'b1, 1'b0);
        tick();
        chk("b_acq1", {30'd0, b_state}, 1);
        tick();
        tick();
        chk("b_sync_state", {30'd0, b_state}, 2);
        chk("b_sync_ok", {31'd0, b_sync_ok}, 1);
        chk("b_comma_det", {31'd0, b_comma_det}, 1);
        chk("b_err_total", {28'd0, b_err_total}, 1);
        drv_b(1'b0, 8'h00, 1'b0, 1'b0);

        // asynchronous reset between edges
        a_word(1'b1, 16'hBC50, 2'b10, 1'b0);
        drv_a(1'b0, 16'h0000, 2'b00, 1'b0);
        chk("pre_rst_a_state", {30'd0, a_state}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_a_state", {30'd0, a_state}, 0);
        chk("arst_a_comma", {31'd0, a_comma_det}, 0);
        chk("arst_a_err_total", {16'd0, a_err_total}, 0);
        chk("arst_b_state", {30'd0, b_state}, 0);
        chk("arst_b_sync_ok", {31'd0, b_sync_ok}, 0);
        chk("arst_b_link_up", {31'd0, b_link_up}, 0);
        chk("arst_b_err_total", {28'd0, b_err_total}, 0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/wr_ep_rx_sync_fsm.md
Name: wr_ep_rx_sync_fsm

Overview:
- Receive-side link-synchronisation block for the WR endpoint PCS.
- Consumes the 8b/10b-decoded word stream (rx_data/rx_k/rx_enc_err) and detects K28.5 commas at the correct byte lane.
- Runs an acquire/sync/error-tolerance state machine and produces sync_ok and a debounced link_up for the MAC and PTP layers.
- Parametrised successor to the fixed 16-bit endpoint path: configurable byte-lane count, thresholds and debounce, plus a saturating error counter.

Parameters:
- BYTES, 2, decoded byte lanes per word (1..4); data width = 8*BYTES.
- ACQ_COMMAS, 3, consecutive-acceptance aligned commas required to enter SYNC (>=1).
- MAX_ERRS, 4, error level at which SYNC is lost (>=1).
- GOOD_RUN, 4, consecutive good words that decrement the error level by one (>=1).
- LINK_UP_DLY, 16, valid words in SYNC before link_up asserts (>=1).
- CNT_W, 16, width of err_total.

Ports:
- clk_125m  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_valid  in  1  qualifies the current decoded word; low = word ignored.
- rx_data  in  8*BYTES  decoded data; lane i = bits [8i+7:8i].
- rx_k  in  BYTES  K-flag per lane.
- rx_enc_err  in  1  code-group or disparity error for the word.
- err_clr  in  1  synchronous clear of err_total.
- state  out  2  0=LOS, 1=ACQ, 2=SYNC.
- sync_ok  out  1  high while state==SYNC.
- link_up  out  1  debounced link indication.
- comma_det  out  1  one-cycle pulse for each aligned comma word.
- err_total  out  CNT_W  saturating count of bad words.

Behaviour:
- Reset (async assert, sync release): state=LOS, sync_ok=0, link_up=0, comma_det=0, err_total=0; all internal counters=0.
- All outputs are registered and reflect the word sampled on the previous edge (latency 1).
- Word classification, only when rx_valid=1:
  - aligned comma: lane BYTES-1 has k=1 and data 0xBC, no other lane has k=1 with 0xBC, and rx_enc_err=0.
  - bad: rx_enc_err=1, or 0xBC with k=1 on any lane other than BYTES-1 (misaligned comma).
  - good: any word that is not bad.
- rx_valid=0: the FSM, all counters and err_total hold; comma_det=0.
- LOS:
  - aligned comma -> ACQ, comma_cnt=1; if ACQ_COMMAS==1, go directly to SYNC.
  - any other word -> stay in LOS.
- ACQ:
  - aligned comma -> comma_cnt++; on reaching ACQ_COMMAS -> SYNC.
  - bad word -> LOS, comma_cnt=0.
  - good non-comma word -> hold.
- Entry to SYNC clears err_level, good_cnt and up_cnt.
- SYNC:
  - bad word -> err_level++ and good_cnt=0. If the new err_level==MAX_ERRS -> LOS; sync_ok and link_up drop on the same edge.
  - good word with err_level>0 -> good_cnt++. When good_cnt reaches GOOD_RUN: err_level-- and good_cnt=0.
  - good word with err_level==0 -> good_cnt held at 0.
- link_up:
  - up_cnt counts valid words in SYNC and saturates at LINK_UP_DLY.
  - link_up=1 when up_cnt==LINK_UP_DLY and state==SYNC.
  - Bad words do not reset up_cnt; leaving SYNC does.
- comma_det=1 for every aligned comma word, in any state.
- err_total:
  - +1 per bad word in any state; saturates at all-ones.
  - err_clr alone -> 0.
  - err_clr together with a bad word -> 1.
- Reset asserted mid-operation: immediate return to reset values regardless of state.

Test Plan:
- Reset, then 3 aligned commas (BYTES=2, rx_data=16'hBC50, rx_k=2'b10) -> state 0->1->1->2; sync_ok=1 one cycle after the 3rd comma; comma_det pulses three times.
- In SYNC, 16 good valid words -> link_up rises exactly after the 16th; 16 words with rx_valid=0 interleaved -> no advance during those cycles.
- In SYNC with link_up=1:
  - 4 consecutive rx_enc_err words -> state=LOS, sync_ok=0, link_up=0, err_total=4.
  - Pattern of 3 errors, 4 good, 1 error -> still SYNC, err_level=3.
- In ACQ after 2 commas, misaligned comma (rx_data=16'h50BC, rx_k=2'b01) -> LOS, err_total+1, comma_det=0.
- err_total preset near saturation via 2^CNT_W-1 bad words (CNT_W=4 build): 20 bad words -> holds 15. err_clr with a bad word on the same edge -> 1.
- BYTES=1 build: commas rx_data=8'hBC, rx_k=1 -> SYNC. Assert rst_n=0 asynchronously between edges -> all outputs 0 immediately.
